// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode operands and control, detects
// load-use hazards (bubble + upstream hold), registers operand forwarding
// selects and keeps a saturating count of inserted bubbles.
module id_ex_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_W   = 4,
   parameter logic [1:0]  MEM_SEL = 2'b01,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic              STALL,
   input  logic              in_VALID,
   input  logic [REG_W-1:0]  in_RA,
   input  logic [REG_W-1:0]  in_RB,
   input  logic [REG_W-1:0]  in_WC,
   input  logic [DATA_W-1:0] in_PC,
   input  logic [DATA_W-1:0] in_PRA,
   input  logic [DATA_W-1:0] in_PRB,
   input  logic [DATA_W-1:0] in_se_out,
   input  logic              in_S_MXSE,
   input  logic [4:0]        in_OP_ALU,
   input  logic              in_W_DM,
   input  logic [1:0]        in_S_MXRB,
   input  logic              in_W_RB,
   input  logic [REG_W-1:0]  in_MEM_WC,
   input  logic              in_MEM_W_RB,
   output logic              out_VALID,
   output logic [REG_W-1:0]  out_RA,
   output logic [REG_W-1:0]  out_RB,
   output logic [REG_W-1:0]  out_WC,
   output logic [DATA_W-1:0] out_PC,
   output logic [DATA_W-1:0] out_PRA,
   output logic [DATA_W-1:0] out_PRB,
   output logic [DATA_W-1:0] out_se_out,
   output logic              out_S_MXSE,
   output logic [4:0]        out_OP_ALU,
   output logic              out_W_DM,
   output logic [1:0]        out_S_MXRB,
   output logic              out_W_RB,
   output logic [1:0]        out_FWD_A,
   output logic [1:0]        out_FWD_B,
   output logic              out_HOLD,
   output logic [CNT_W-1:0]  out_BUBBLES
);

   localparam logic [1:0] FWD_BANK = 2'b00;
   localparam logic [1:0] FWD_EX   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  ra;
      logic [REG_W-1:0]  rb;
      logic [REG_W-1:0]  wc;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pra;
      logic [DATA_W-1:0] prb;
      logic [DATA_W-1:0] se_out;
      logic              s_mxse;
      logic [4:0]        op_alu;
      logic              w_dm;
      logic [1:0]        s_mxrb;
      logic              w_rb;
      logic [1:0]        fwd_a;
      logic [1:0]        fwd_b;
   } ex_t;

   ex_t              ex_q, ex_d;
   logic [CNT_W-1:0] bub_q, bub_d;
   logic             hazard;
   logic [1:0]       fwd_a, fwd_b;

   // Load-use hazard: a load in EX whose destination feeds the decoding instruction
   always_comb begin
      hazard = in_VALID & ex_q.valid & ex_q.w_rb & (ex_q.s_mxrb == MEM_SEL)
             & ((ex_q.wc == in_RA) | (ex_q.wc == in_RB));
   end

   // Forwarding selects from pre-edge state; the younger EX result beats MEM
   always_comb begin
      fwd_a = FWD_BANK;
      fwd_b = FWD_BANK;
      if (ex_q.valid && ex_q.w_rb && (ex_q.wc == in_RA))
         fwd_a = FWD_EX;
      else if (in_MEM_W_RB && (in_MEM_WC == in_RA))
         fwd_a = FWD_MEM;
      if (ex_q.valid && ex_q.w_rb && (ex_q.wc == in_RB))
         fwd_b = FWD_EX;
      else if (in_MEM_W_RB && (in_MEM_WC == in_RB))
         fwd_b = FWD_MEM;
   end

   // Upstream freeze; a flush releases it and reset forces it low
   always_comb begin
      out_HOLD = ~RESET & ~FLUSH & (STALL | hazard);
   end

   // Next-state selection: flush > stall > bubble > load
   always_comb begin
      ex_d  = ex_q;
      bub_d = bub_q;
      if (FLUSH) begin
         ex_d.valid = 1'b0;
         ex_d.w_rb  = 1'b0;
         ex_d.w_dm  = 1'b0;
      end else if (STALL) begin
         ex_d = ex_q;
      end else if (hazard) begin
         ex_d.valid = 1'b0;
         ex_d.w_rb  = 1'b0;
         ex_d.w_dm  = 1'b0;
         ex_d.fwd_a = FWD_BANK;
         ex_d.fwd_b = FWD_BANK;
         if (bub_q != {CNT_W{1'b1}})
            bub_d = bub_q + CNT_W'(1);
      end else begin
         ex_d.valid  = in_VALID;
         ex_d.ra     = in_RA;
         ex_d.rb     = in_RB;
         ex_d.wc     = in_WC;
         ex_d.pc     = in_PC;
         ex_d.pra    = in_PRA;
         ex_d.prb    = in_PRB;
         ex_d.se_out = in_se_out;
         ex_d.s_mxse = in_S_MXSE;
         ex_d.op_alu = in_OP_ALU;
         ex_d.w_dm   = in_W_DM & in_VALID;
         ex_d.s_mxrb = in_S_MXRB;
         ex_d.w_rb   = in_W_RB & in_VALID;
         ex_d.fwd_a  = fwd_a;
         ex_d.fwd_b  = fwd_b;
      end
   end

   // Pipeline register and bubble counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_q  <= '0;
         bub_q <= '0;
      end else begin
         ex_q  <= ex_d;
         bub_q <= bub_d;
      end
   end

   // Output mapping
   always_comb begin
      out_VALID   = ex_q.valid;
      out_RA      = ex_q.ra;
      out_RB      = ex_q.rb;
      out_WC      = ex_q.wc;
      out_PC      = ex_q.pc;
      out_PRA     = ex_q.pra;
      out_PRB     = ex_q.prb;
      out_se_out  = ex_q.se_out;
      out_S_MXSE  = ex_q.s_mxse;
      out_OP_ALU  = ex_q.op_alu;
      out_W_DM    = ex_q.w_dm;
      out_S_MXRB  = ex_q.s_mxrb;
      out_W_RB    = ex_q.w_rb;
      out_FWD_A   = ex_q.fwd_a;
      out_FWD_B   = ex_q.fwd_b;
      out_BUBBLES = bub_q;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a vector table with expected controls, a scoreboard
// queue of expected results, and a bubble-counter saturation sequence run on
// a narrow-counter instance alongside the default one.
module tb_id_ex_stage;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned SAT_W  = 4;
   localparam int unsigned DW     = 3*REG_W + 4*DATA_W + 1 + 5 + 2;

   localparam int K_RST = 0, K_LOAD = 1, K_STALL = 2, K_BUB = 3, K_FLUSH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, flush, stall, i_valid, i_mxse, i_wdm, i_wrb, i_mwrb;
   logic [REG_W-1:0]  i_ra, i_rb, i_wc, i_mwc;
   logic [DATA_W-1:0] i_pc, i_pra, i_prb, i_se;
   logic [4:0]        i_op;
   logic [1:0]        i_mxrb;

   logic              o_valid, o_mxse, o_wdm, o_wrb, o_hold;
   logic [REG_W-1:0]  o_ra, o_rb, o_wc;
   logic [DATA_W-1:0] o_pc, o_pra, o_prb, o_se;
   logic [4:0]        o_op;
   logic [1:0]        o_mxrb, o_fa, o_fb;
   logic [CNT_W-1:0]  o_bub;

   logic              s_valid, s_mxse, s_wdm, s_wrb, s_hold;
   logic [REG_W-1:0]  s_ra, s_rb, s_wc;
   logic [DATA_W-1:0] s_pc, s_pra, s_prb, s_se;
   logic [4:0]        s_op;
   logic [1:0]        s_mxrb, s_fa, s_fb;
   logic [SAT_W-1:0]  s_bub;

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .MEM_SEL(2'b01), .CNT_W(CNT_W)) u_dut (
      .CLK(clk), .RESET(rst), .FLUSH(flush), .STALL(stall), .in_VALID(i_valid),
      .in_RA(i_ra), .in_RB(i_rb), .in_WC(i_wc), .in_PC(i_pc), .in_PRA(i_pra),
      .in_PRB(i_prb), .in_se_out(i_se), .in_S_MXSE(i_mxse), .in_OP_ALU(i_op),
      .in_W_DM(i_wdm), .in_S_MXRB(i_mxrb), .in_W_RB(i_wrb), .in_MEM_WC(i_mwc),
      .in_MEM_W_RB(i_mwrb), .out_VALID(o_valid), .out_RA(o_ra), .out_RB(o_rb),
      .out_WC(o_wc), .out_PC(o_pc), .out_PRA(o_pra), .out_PRB(o_prb),
      .out_se_out(o_se), .out_S_MXSE(o_mxse), .out_OP_ALU(o_op), .out_W_DM(o_wdm),
      .out_S_MXRB(o_mxrb), .out_W_RB(o_wrb), .out_FWD_A(o_fa), .out_FWD_B(o_fb),
      .out_HOLD(o_hold), .out_BUBBLES(o_bub));

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .MEM_SEL(2'b01), .CNT_W(SAT_W)) u_sat (
      .CLK(clk), .RESET(rst), .FLUSH(flush), .STALL(stall), .in_VALID(i_valid),
      .in_RA(i_ra), .in_RB(i_rb), .in_WC(i_wc), .in_PC(i_pc), .in_PRA(i_pra),
      .in_PRB(i_prb), .in_se_out(i_se), .in_S_MXSE(i_mxse), .in_OP_ALU(i_op),
      .in_W_DM(i_wdm), .in_S_MXRB(i_mxrb), .in_W_RB(i_wrb), .in_MEM_WC(i_mwc),
      .in_MEM_W_RB(i_mwrb), .out_VALID(s_valid), .out_RA(s_ra), .out_RB(s_rb),
      .out_WC(s_wc), .out_PC(s_pc), .out_PRA(s_pra), .out_PRB(s_prb),
      .out_se_out(s_se), .out_S_MXSE(s_mxse), .out_OP_ALU(s_op), .out_W_DM(s_wdm),
      .out_S_MXRB(s_mxrb), .out_W_RB(s_wrb), .out_FWD_A(s_fa), .out_FWD_B(s_fb),
      .out_HOLD(s_hold), .out_BUBBLES(s_bub));

   typedef struct {
      int                kind;
      logic              rst, flush, stall, valid, mxse, wdm, wrb, mwrb;
      logic [REG_W-1:0]  ra, rb, wc, mwc;
      logic [DATA_W-1:0] pc, pra, prb, se;
      logic [4:0]        op;
      logic [1:0]        mxrb;
      logic              e_hold, e_valid, e_wrb, e_wdm, chk_fwd;
      logic [1:0]        e_fa, e_fb;
      logic [CNT_W-1:0]  e_bub;
   } vec_t;

   typedef struct {
      logic             valid, wrb, wdm, chk_fwd, chk_data;
      logic [1:0]       fa, fb;
      logic [CNT_W-1:0] bub;
      logic [DW-1:0]    data;
   } exp_t;

   vec_t      vecs[$];
   exp_t      exp_q[$];
   int        cnt_q[$];
   int        errors = 0;
   int        checks = 0;
   logic [DW-1:0] img;
   logic      img_ok;

   function automatic vec_t mkv(int kind, int bub);
      vec_t v;
      v = '{default: '0};
      v.kind = kind;  v.e_bub = CNT_W'(bub);  v.chk_fwd = 1'b1;
      v.pc = $urandom;  v.pra = $urandom;  v.prb = $urandom;  v.se = $urandom;
      v.op = 5'($urandom);  v.mxse = 1'($urandom);
      return v;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst;  flush = v.flush;  stall = v.stall;  i_valid = v.valid;
      i_ra = v.ra;  i_rb = v.rb;  i_wc = v.wc;  i_pc = v.pc;  i_pra = v.pra;
      i_prb = v.prb;  i_se = v.se;  i_mxse = v.mxse;  i_op = v.op;  i_wdm = v.wdm;
      i_mxrb = v.mxrb;  i_wrb = v.wrb;  i_mwc = v.mwc;  i_mwrb = v.mwrb;
   endtask

   initial begin
      vec_t v;
      exp_t e;
      int   n;
      img = '0;  img_ok = 1'b0;
      v = mkv(K_RST, 0);  drive(v);

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         v = mkv(K_RST, 0);  v.rst = 1;  v.flush = 1'($urandom);  v.stall = 1'($urandom);
         v.valid = 1'($urandom);  v.ra = 4'($urandom);  v.rb = 4'($urandom);  v.wc = 4'($urandom);
         v.wrb = 1'($urandom);  v.wdm = 1'($urandom);  v.mxrb = 2'($urandom);
         v.mwc = 4'($urandom);  v.mwrb = 1'($urandom);  vecs.push_back(v);
      end
      // Pass-through
      v = mkv(K_LOAD, 0);  v.valid = 1;  v.pra = 32'h1234;  v.op = 5'h03;  v.wc = 4'h5;
      v.ra = 1;  v.rb = 2;  v.wrb = 1;  v.e_valid = 1;  v.e_wrb = 1;  vecs.push_back(v);
      // Load to r3, RA hits the ALU result in EX
      v = mkv(K_LOAD, 0);  v.valid = 1;  v.wc = 3;  v.mxrb = 2'b01;  v.wrb = 1;  v.ra = 5;  v.rb = 6;
      v.e_valid = 1;  v.e_wrb = 1;  v.e_fa = 2'b01;  vecs.push_back(v);
      // Load-use: bubble, then consumer loads with MEM forward
      v = mkv(K_BUB, 1);  v.valid = 1;  v.ra = 3;  v.rb = 8;  v.wc = 9;  v.wrb = 1;  v.mwc = 3;  v.mwrb = 1;
      v.e_hold = 1;  vecs.push_back(v);
      v.kind = K_LOAD;  v.e_hold = 0;  v.e_valid = 1;  v.e_wrb = 1;  v.e_fa = 2'b10;  vecs.push_back(v);
      // Forward priority: EX beats MEM
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.wc = 7;  v.wrb = 1;  v.ra = 1;  v.rb = 2;
      v.e_valid = 1;  v.e_wrb = 1;  vecs.push_back(v);
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.ra = 4;  v.rb = 7;  v.wc = 10;  v.wrb = 1;  v.mwc = 7;  v.mwrb = 1;
      v.e_valid = 1;  v.e_wrb = 1;  v.e_fb = 2'b01;  vecs.push_back(v);
      // Store to r7 (no bank write), then MEM forward wins
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.wc = 7;  v.wdm = 1;  v.e_valid = 1;  v.e_wdm = 1;  vecs.push_back(v);
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.ra = 11;  v.rb = 7;  v.wc = 12;  v.wrb = 1;  v.mwc = 7;  v.mwrb = 1;
      v.e_valid = 1;  v.e_wrb = 1;  v.e_fb = 2'b10;  vecs.push_back(v);
      // Flush concurrent with a hazard
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.wc = 3;  v.mxrb = 2'b01;  v.wrb = 1;
      v.e_valid = 1;  v.e_wrb = 1;  vecs.push_back(v);
      v = mkv(K_FLUSH, 1);  v.flush = 1;  v.valid = 1;  v.ra = 3;  v.wrb = 1;  v.wdm = 1;
      v.chk_fwd = 0;  vecs.push_back(v);
      // Load then three stall cycles with different inputs
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.ra = 1;  v.rb = 2;  v.wc = 4;  v.wrb = 1;  v.mwc = 2;  v.mwrb = 1;
      v.e_valid = 1;  v.e_wrb = 1;  v.e_fb = 2'b10;  vecs.push_back(v);
      for (int i = 0; i < 3; i++) begin
         v = mkv(K_STALL, 1);  v.stall = 1;  v.valid = 1;  v.ra = 4'($urandom);  v.rb = 4'($urandom);
         v.wc = 4'($urandom);  v.wrb = 1'($urandom);  v.wdm = 1'($urandom);  v.mxrb = 2'($urandom);
         v.mwc = 4'($urandom);  v.mwrb = 1;  v.e_hold = 1;  v.e_valid = 1;  v.e_wrb = 1;  v.e_fb = 2'b10;
         vecs.push_back(v);
      end
      // Stall overrides a hazard, then the bubble and the forwarded consumer
      v = mkv(K_LOAD, 1);  v.valid = 1;  v.wc = 6;  v.mxrb = 2'b01;  v.wrb = 1;
      v.e_valid = 1;  v.e_wrb = 1;  vecs.push_back(v);
      v = mkv(K_STALL, 1);  v.stall = 1;  v.valid = 1;  v.ra = 6;  v.wc = 13;  v.wrb = 1;
      v.e_hold = 1;  v.e_valid = 1;  v.e_wrb = 1;  vecs.push_back(v);
      v.kind = K_BUB;  v.stall = 0;  v.e_bub = 2;  v.e_valid = 0;  v.e_wrb = 0;  vecs.push_back(v);
      v.kind = K_LOAD;  v.mwc = 6;  v.mwrb = 1;  v.e_hold = 0;  v.e_valid = 1;  v.e_wrb = 1;  v.e_fa = 2'b10;
      vecs.push_back(v);
      // Reset in the middle of a hazard
      v = mkv(K_LOAD, 2);  v.valid = 1;  v.wc = 2;  v.mxrb = 2'b01;  v.wrb = 1;
      v.e_valid = 1;  v.e_wrb = 1;  vecs.push_back(v);
      v = mkv(K_RST, 0);  v.rst = 1;  v.valid = 1;  v.ra = 2;  v.stall = 1;  vecs.push_back(v);
      // Invalid instruction: write enables forced low
      v = mkv(K_LOAD, 0);  v.valid = 0;  v.wrb = 1;  v.wdm = 1;  v.wc = 9;  v.mxrb = 2'b01;
      vecs.push_back(v);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         #1;
         chk($sformatf("hold[%0d]", i), 256'(o_hold), 256'(v.e_hold));
         case (v.kind)
            K_RST:   begin img = '0;  img_ok = 1'b1; end
            K_LOAD:  begin img = {v.ra, v.rb, v.wc, v.pc, v.pra, v.prb, v.se, v.mxse, v.op, v.mxrb};
                           img_ok = 1'b1; end
            K_STALL: ;
            default: img_ok = 1'b0;
         endcase
         e.valid = v.e_valid;  e.wrb = v.e_wrb;  e.wdm = v.e_wdm;  e.fa = v.e_fa;  e.fb = v.e_fb;
         e.bub = v.e_bub;  e.chk_fwd = v.chk_fwd;  e.chk_data = img_ok;  e.data = img;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("valid[%0d]", i), 256'(o_valid), 256'(e.valid));
         chk($sformatf("w_rb[%0d]", i), 256'(o_wrb), 256'(e.wrb));
         chk($sformatf("w_dm[%0d]", i), 256'(o_wdm), 256'(e.wdm));
         chk($sformatf("bubbles[%0d]", i), 256'(o_bub), 256'(e.bub));
         if (e.chk_fwd) begin
            chk($sformatf("fwd_a[%0d]", i), 256'(o_fa), 256'(e.fa));
            chk($sformatf("fwd_b[%0d]", i), 256'(o_fb), 256'(e.fb));
         end
         if (e.chk_data)
            chk($sformatf("data[%0d]", i),
                256'({o_ra, o_rb, o_wc, o_pc, o_pra, o_prb, o_se, o_mxse, o_op, o_mxrb}), 256'(e.data));
      end

      // Counter saturation: repeated load/consumer pairs
      @(negedge clk);
      v = mkv(K_RST, 0);  v.rst = 1;  drive(v);
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         v = mkv(K_LOAD, 0);  v.valid = 1;  v.wc = 3;  v.mxrb = 2'b01;  v.wrb = 1;  drive(v);
         @(posedge clk);
         @(negedge clk);
         v.ra = 3;  v.wc = 9;  v.mxrb = 2'b00;  drive(v);
         #1;
         chk($sformatf("sat_hold[%0d]", i), 256'(o_hold), 256'(1));
         cnt_q.push_back(i + 1);
         @(posedge clk);
         #1;
         n = cnt_q.pop_front();
         chk($sformatf("sat_valid[%0d]", i), 256'(s_valid), 256'(0));
         chk($sformatf("sat_cnt[%0d]", i), 256'(s_bub), 256'((n > 15) ? 15 : n));
         chk($sformatf("wide_cnt[%0d]", i), 256'(o_bub), 256'(n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
